// File: rtl/aoe_initiator.sv
// aoe_initiator: host-side request/response initiator over mini_mac payload byte streams.
// Define AOE_TIMEOUT_EN to enable the response timeout (TIMEOUT_CYCLES).
module aoe_initiator
`ifdef AOE_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1250000
)
`endif
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        done,
    output logic [1:0]  done_err,
    output logic [15:0] done_seq,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_eof,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_eof
);
    typedef enum logic [2:0] {IDLE, TX_HDR, TX_PAY, RX_HDR, RX_DATA, RX_DRAIN, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] seq_q, seq_d, len_q, len_d, cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  err_q, err_d;
    logic [7:0]  hdr [0:8];
    logic [7:0]  exp_byte;
    logic        hdr_last;
`ifdef AOE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q, to_d;
`endif
    always_comb begin
        hdr = '{write_q ? 8'h10 : 8'h20, seq_q[15:8], seq_q[7:0], addr_q[31:24], addr_q[23:16],
                addr_q[15:8], addr_q[7:0], len_q[15:8], len_q[7:0]};
        // Response echoes the request header with the op bumped by one
        exp_byte = (idx_q == 4'd0) ? (write_q ? 8'h11 : 8'h21) : hdr[idx_q];
        hdr_last = idx_q == (write_q ? 4'd2 : 4'd8);
    end
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        idx_d     = idx_q;
        err_d     = err_q;
        cmd_ready = state_q == IDLE;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 8'h00;
        rd_last   = 1'b0;
        done      = 1'b0;
        done_err  = 2'd0;
        done_seq  = 16'd0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_eof    = 1'b0;
        rx_ready  = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                write_d = cmd_write;
                addr_d  = cmd_addr;
                len_d   = cmd_len;
                idx_d   = 4'd0;
                err_d   = (cmd_len == 16'd0) ? 2'd3 : 2'd0;
                state_d = (cmd_len == 16'd0) ? DONE : TX_HDR;
            end
            TX_HDR: begin
                tx_valid = 1'b1;
                tx_data  = hdr[idx_q];
                tx_eof   = !write_q && idx_q == 4'd8;
                if (tx_ready) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd8) begin
                        idx_d   = 4'd0;
                        cnt_d   = len_q;
                        state_d = write_q ? TX_PAY : RX_HDR;
                    end
                end
            end
            TX_PAY: begin
                tx_valid = wr_valid;
                wr_ready = tx_ready;
                tx_data  = wr_data;
                tx_eof   = wr_valid && cnt_q == 16'd1;
                if (wr_valid && tx_ready) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = RX_HDR;
                end
            end
            RX_HDR: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    idx_d = idx_q + 4'd1;
                    // An eof is only legal on the final byte of a matching ack
                    if (rx_data != exp_byte || (rx_eof && !(hdr_last && write_q))) err_d = 2'd1;
                    if (rx_eof) state_d = DONE;
                    else if (rx_data != exp_byte || (hdr_last && write_q)) state_d = RX_DRAIN;
                    else if (hdr_last) state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                rd_valid = rx_valid;
                rx_ready = rd_ready;
                rd_data  = rx_data;
                rd_last  = rx_valid && cnt_q == 16'd1;
                if (rx_valid && rd_ready) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_d = rx_eof ? DONE : RX_DRAIN;
                    else if (rx_eof) begin
                        err_d   = 2'd1;
                        state_d = DONE;
                    end
                end
            end
            RX_DRAIN: begin
                rx_ready = 1'b1;
                if (rx_valid && rx_eof) state_d = DONE;
            end
            DONE: begin
                done     = 1'b1;
                done_err = err_q;
                done_seq = seq_q;
                seq_d    = seq_q + 16'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AOE_TIMEOUT_EN
        to_d = '0;
        if ((state_q == RX_HDR || state_q == RX_DATA || state_q == RX_DRAIN) && !(rx_valid && rx_ready)) begin
            to_d = to_q + TW'(1);
            if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                to_d    = '0;
                err_d   = 2'd2;
                state_d = DONE;
            end
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            seq_q   <= 16'd0;
            len_q   <= 16'd0;
            cnt_q   <= 16'd0;
            addr_q  <= 32'd0;
            write_q <= 1'b0;
            idx_q   <= 4'd0;
            err_q   <= 2'd0;
`ifdef AOE_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
`ifdef AOE_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end
endmodule
